// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared definitions for the E-stage multiply/divide unit.
//   - md_op_e      : MD operation codes. These mirror the `MD_* codes that sit beside `ALU_* in const.v.
//   - md_state_e   : sequencer states.
//   - md_res_t     : the result of one operation, plus a flag that says whether HI/LO take it.
//   - md_is_arith  : true for the ops that occupy the unit (mult/multu/div/divu).
//   - md_compute   : the full 64-bit arithmetic for one op, computed in a single step.
package mult_div_unit_pkg;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;  // 0 means the op completes but leaves HI/LO untouched (divide by zero)
  } md_res_t;

  function automatic logic md_is_arith(input logic [3:0] op);
    md_is_arith = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic md_res_t md_compute(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] prod;
    logic [31:0] b_nz;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    md_res_t     res;
    res   = '0;
    prod  = 64'd0;
    // Substitute 1 for a zero divisor so the divider never sees 0; the result is discarded in that case.
    b_nz  = (b == 32'd0) ? 32'd1 : b;
    // Signed divide works on magnitudes. 0x80000000 negates to itself, which is still correct as an
    // unsigned 2^31, so the overflow case 0x80000000 / -1 produces 0x80000000 with remainder 0.
    abs_a = a[31] ? (32'd0 - a) : a;
    abs_b = b_nz[31] ? (32'd0 - b_nz) : b_nz;
    q_mag = abs_a / abs_b;
    r_mag = abs_a % abs_b;
    case (op)
      MD_MULT: begin
        prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res.hi = prod[63:32];
        res.lo = prod[31:0];
        res.wr = 1'b1;
      end
      MD_MULTU: begin
        prod   = {32'd0, a} * {32'd0, b};
        res.hi = prod[63:32];
        res.lo = prod[31:0];
        res.wr = 1'b1;
      end
      MD_DIV: begin
        // The quotient truncates toward zero. The remainder takes the sign of the dividend.
        res.lo = (a[31] ^ b_nz[31]) ? (32'd0 - q_mag) : q_mag;
        res.hi = a[31] ? (32'd0 - r_mag) : r_mag;
        res.wr = (b != 32'd0);
      end
      MD_DIVU: begin
        res.lo = a / b_nz;
        res.hi = a % b_nz;
        res.wr = (b != 32'd0);
      end
      default: begin
        res = '0;
      end
    endcase
    md_compute = res;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit that holds the HI/LO architectural registers.
//   Each arithmetic op is evaluated in full on its start edge and held internally. The op then
//   occupies the unit for a fixed MULT_CYCLES / DIV_CYCLES before the result is committed to HI/LO.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset; clears HI/LO and abandons any op in flight
//   A, B   : forwarded rs / rt operands
//   MD_op  : MD operation code (md_op_e)
//   start  : one-cycle pulse that accompanies a mult/multu/div/divu op
//   busy   : high while an op is in flight
//   HI, LO : architectural HI/LO registers
//   MD_out : combinational read port; HI for mfhi, LO for mflo, otherwise 0
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MD_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic             res_wr_q, res_wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  md_res_t          res_s;

  // Arithmetic result for the operands currently presented on A/B.
  always_comb begin
    res_s = md_compute(MD_op, A, B);
  end

  // Next-state logic: accept a start, count down while running, commit the result, and apply mthi/mtlo.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && md_is_arith(MD_op)) begin
          state_d  = ST_RUN;
          cnt_d    = ((MD_op == MD_MULT) || (MD_op == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
          res_hi_d = res_s.hi;
          res_lo_d = res_s.lo;
          res_wr_d = res_s.wr;
        end else if (MD_op == MD_MTHI) begin
          hi_d = A;
        end else if (MD_op == MD_MTLO) begin
          lo_d = A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // start, mthi and mtlo are all ignored here. The hazard unit keeps them from arriving.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // mfhi/mflo read port. The stall rule keeps it from being used while busy.
  always_comb begin
    case (MD_op)
      MD_MFHI: MD_out = hi_q;
      MD_MFLO: MD_out = lo_q;
      default: MD_out = 32'd0;
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit; sits beside the E-stage ALU and consumes the same forwarded operands A/B.
- Runs mult/multu/div/divu over a fixed multi-cycle latency and holds the HI/LO architectural registers.
- Serves mthi/mtlo/mfhi/mflo.
- Exposes busy to the hazard unit, which stalls any MD instruction in D while start|busy.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- MD_op  input  4  operation code (`MD_* in const.v).
- start  input  1  one-cycle pulse with a mult/multu/div/divu op in E.
- busy  output  1  high while an operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.
- MD_out  output  32  combinational read: HI for `MD_mfhi, LO for `MD_mflo, else 0.

Behaviour:
- Reset (async, any time, including mid-operation): HI=0, LO=0, busy=0, counter=0, state=IDLE; any pending result is discarded.
- FSM has two states, IDLE and RUN, with a down-counter of width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- IDLE -> RUN:
  - Occurs at edge k when start=1 and MD_op is mult/multu/div/divu.
  - At that edge, latch the op and compute the full result into internal regs res_hi/res_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES. busy=1 from after edge k.
- In RUN, the counter decrements each edge.
- Leaving RUN:
  - At the edge where the counter reaches 1, write HI<=res_hi and LO<=res_lo, go to IDLE, busy=0.
  - Net effect: busy is high for exactly N cycles after the start edge. HI/LO become visible at edge k+N.
- start with a non-mult/div MD_op: ignored.
- start while busy: ignored, since the hazard unit prevents it; there is no queueing.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - multu: the same, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend (A).
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B==0) for div/divu: the unit still runs busy for DIV_CYCLES, and HI/LO are left unchanged at completion.
- mthi / mtlo:
  - Write HI<=A or LO<=A at the edge, only when busy=0.
  - If busy=1 the write is ignored; the hazard unit guarantees this does not occur.
  - mthi/mtlo never assert busy.
- mfhi / mflo: MD_out is combinational from the current HI/LO. While busy, it returns the old values, and the stall rule prevents that read.
- No retriggering: after completion, a new start is accepted in the very next cycle (back-to-back operations are allowed).

Decomposition:
- `MD_* op codes live in const.v next to `ALU_*: MD_none=0, mult=1, multu=2, div=3, divu=4, mthi=5, mtlo=6, mfhi=7, mflo=8.
- MULT_CYCLES/DIV_CYCLES defaults are also mirrored there.
- No sub-module: the FSM, counter and result registers are written inline.
- The E-stage result mux selects MD_out for mfhi/mflo.

Test Plan:
- Signed mult: A=0xFFFFFFFF, B=2, MD_op=mult, start pulse at edge k.
  - busy=1 for 5 cycles.
  - At k+5: HI=0xFFFFFFFF, LO=0xFFFFFFFE, busy=0.
- Unsigned mult and back-to-back: multu with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
  - Then start div next cycle with A=0xFFFFFFF9 (-7), B=2.
  - After 10 cycles: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Division corners:
  - divu 0xFFFFFFF9/2 -> LO=0x7FFFFFFC, HI=1.
  - div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
  - div 5/0 -> HI/LO keep prior values, and busy still lasts 10 cycles.
- Moves and reads:
  - mthi A=0x12345678, then mtlo A=0x9ABCDEF0.
  - mfhi -> MD_out=0x12345678; mflo -> MD_out=0x9ABCDEF0.
  - busy stays 0 throughout.
- Ignored writes and ignored start: during a running mult, apply mtlo A=0xDEADBEEF and a second start.
  - Both are ignored.
  - The final LO equals the mult result, and busy length is unchanged.
- Async reset mid-operation: assert reset between clock edges 2 cycles into a div.
  - busy=0 and HI=LO=0 immediately, with no clock edge required.
  - After deassert, a fresh mult completes correctly.
